pipe_regfile_sb: RTL and testbench

//  Parametrised multi-port register file with write-through bypass and a per-register

---
 rtl/rf_pkg.sv | 13 +
 rtl/rf_scoreboard.sv | 77 +++++++
 rtl/pipe_regfile_sb.sv | 82 ++++++++
 tb/tb_pipe_regfile_sb.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// rf_pkg: shared sizing constants for the pipelined register file and its scoreboard.
//   RF_WIDTH     default data width
//   RF_DEPTH     default register count (power of two)
//   RF_AW        address width derived from RF_DEPTH
//   RF_RESET_VAL default contents loaded into every register on reset
package rf_pkg;

    localparam int              RF_WIDTH     = 16;
    localparam int              RF_DEPTH     = 16;
    localparam int              RF_AW        = $clog2(RF_DEPTH);
    localparam logic [15:0]     RF_RESET_VAL = 16'hABCD;

endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register pending bits, issue stall decision and pending count.
//   clk, rst          clock, synchronous active-high reset
//   raddr_1/2         operand read addresses of the issuing instruction
//   rd1_use/rd2_use   operand n is actually consumed
//   iss_en, iss_dst   issue request and its destination register
//   wr_en, waddr      writeback enable/address (clears the pending bit)
//   stall             combinational: issue blocked this cycle (RAW or WAW)
//   pend_cnt          registered number of pending registers
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int DEPTH    = RF_DEPTH,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b0,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] raddr_1,
    input  logic [AW-1:0] raddr_2,
    input  logic          rd1_use,
    input  logic          rd2_use,
    input  logic          iss_en,
    input  logic [AW-1:0] iss_dst,
    input  logic          wr_en,
    input  logic [AW-1:0] waddr,
    output logic          stall,
    output logic [AW:0]   pend_cnt
);

    logic [DEPTH-1:0] pending_q, pending_d;
    logic [AW:0]      pend_cnt_q, pend_cnt_d;

    logic busy_1, busy_2, waw, iss_acc, set_v, inc, dec;

    // A pending operand is not a hazard when its producer writes back this
    // very cycle and the value is forwarded through the bypass path.
    always_comb begin
        busy_1 = pending_q[raddr_1] && !(BYPASS && wr_en && (waddr == raddr_1));
        busy_2 = pending_q[raddr_2] && !(BYPASS && wr_en && (waddr == raddr_2));
        if (ZERO_REG && (raddr_1 == '0)) busy_1 = 1'b0;
        if (ZERO_REG && (raddr_2 == '0)) busy_2 = 1'b0;
        // The outstanding write retiring now frees the destination for reuse.
        waw     = pending_q[iss_dst] && !(wr_en && (waddr == iss_dst));
        stall   = iss_en && ((rd1_use && busy_1) || (rd2_use && busy_2) || waw);
        iss_acc = iss_en && !stall;
        set_v   = iss_acc && !(ZERO_REG && (iss_dst == '0));
    end

    // Clear first, then set: a same-address writeback and accepted issue
    // leaves the bit set because the new producer is still in flight.
    always_comb begin
        pending_d = pending_q;
        if (wr_en) pending_d[waddr] = 1'b0;
        if (set_v) pending_d[iss_dst] = 1'b1;
    end

    // Incremental popcount: only real 0->1 and 1->0 transitions count.
    always_comb begin
        inc        = set_v && !pending_q[iss_dst];
        dec        = wr_en && pending_q[waddr] && !(set_v && (iss_dst == waddr));
        pend_cnt_d = pend_cnt_q + (AW+1)'(inc) - (AW+1)'(dec);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q  <= '0;
            pend_cnt_q <= '0;
        end else begin
            pending_q  <= pending_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    assign pend_cnt = pend_cnt_q;

endmodule

// File: rtl/pipe_regfile_sb.sv
// pipe_regfile_sb: two-read / one-write register file with write-through bypass
// and a pending-destination scoreboard that stalls issue on RAW/WAW hazards.
//   clk, rst             clock, synchronous active-high reset (overrides WrX/iss_en)
//   raddr_1/2            read addresses; out_data_1/2 combinational read data
//   rd1_use/rd2_use      issuing instruction consumes operand 1/2
//   iss_en, iss_dst      issue request and destination register
//   stall                combinational issue block
//   WrX, waddr, DataIn   writeback port (1-cycle latency to storage)
//   pend_cnt             registered count of pending registers
module pipe_regfile_sb
    import rf_pkg::*;
#(
    parameter int               WIDTH     = RF_WIDTH,
    parameter int               DEPTH     = RF_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = RF_RESET_VAL,
    parameter bit               BYPASS    = 1'b1,
    parameter bit               ZERO_REG  = 1'b0,
    localparam int              AW        = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    raddr_1,
    input  logic [AW-1:0]    raddr_2,
    output logic [WIDTH-1:0] out_data_1,
    output logic [WIDTH-1:0] out_data_2,
    input  logic             rd1_use,
    input  logic             rd2_use,
    input  logic             iss_en,
    input  logic [AW-1:0]    iss_dst,
    output logic             stall,
    input  logic             WrX,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] DataIn,
    output logic [AW:0]      pend_cnt
);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;

    // Writes to register 0 are dropped when it is hardwired to zero.
    always_comb begin
        mem_d = mem_q;
        if (WrX && !(ZERO_REG && (waddr == '0))) mem_d[waddr] = DataIn;
    end

    always_ff @(posedge clk) begin
        if (rst) mem_q <= {DEPTH{RESET_VAL}};
        else     mem_q <= mem_d;
    end

    // Read priority: hardwired zero, then same-cycle bypass, then storage.
    always_comb begin
        out_data_1 = mem_q[raddr_1];
        if (BYPASS && WrX && (waddr == raddr_1)) out_data_1 = DataIn;
        if (ZERO_REG && (raddr_1 == '0))         out_data_1 = '0;
    end

    always_comb begin
        out_data_2 = mem_q[raddr_2];
        if (BYPASS && WrX && (waddr == raddr_2)) out_data_2 = DataIn;
        if (ZERO_REG && (raddr_2 == '0))         out_data_2 = '0;
    end

    rf_scoreboard #(
        .DEPTH    (DEPTH),
        .BYPASS   (BYPASS),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .raddr_1  (raddr_1),
        .raddr_2  (raddr_2),
        .rd1_use  (rd1_use),
        .rd2_use  (rd2_use),
        .iss_en   (iss_en),
        .iss_dst  (iss_dst),
        .wr_en    (WrX),
        .waddr    (waddr),
        .stall    (stall),
        .pend_cnt (pend_cnt)
    );

endmodule

// File: tb/tb_pipe_regfile_sb.sv
// Three configurations share one stimulus stream:
//   cfg0 BYPASS=1 ZERO_REG=0, cfg1 BYPASS=0 ZERO_REG=0, cfg2 BYPASS=1 ZERO_REG=1.
// Each has its own reference array of register values and pending flags.
module tb_pipe_regfile_sb;
    import rf_pkg::*;

    localparam int W  = RF_WIDTH;
    localparam int D  = RF_DEPTH;
    localparam int AW = RF_AW;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] raddr_1, raddr_2, iss_dst, waddr;
    logic          rd1_use, rd2_use, iss_en, WrX;
    logic [W-1:0]  DataIn;

    logic [W-1:0]  o1 [3];
    logic [W-1:0]  o2 [3];
    logic          st [3];
    logic [AW:0]   pc [3];

    int checks = 0;
    int errors = 0;

    logic [W-1:0]  mm [3][D];
    bit            pp [3][D];

    always #5 clk = ~clk;

    pipe_regfile_sb #(.BYPASS(1'b1), .ZERO_REG(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .raddr_1(raddr_1), .raddr_2(raddr_2),
        .out_data_1(o1[0]), .out_data_2(o2[0]), .rd1_use(rd1_use), .rd2_use(rd2_use),
        .iss_en(iss_en), .iss_dst(iss_dst), .stall(st[0]), .WrX(WrX), .waddr(waddr),
        .DataIn(DataIn), .pend_cnt(pc[0]));

    pipe_regfile_sb #(.BYPASS(1'b0), .ZERO_REG(1'b0)) u_dut1 (
        .clk(clk), .rst(rst), .raddr_1(raddr_1), .raddr_2(raddr_2),
        .out_data_1(o1[1]), .out_data_2(o2[1]), .rd1_use(rd1_use), .rd2_use(rd2_use),
        .iss_en(iss_en), .iss_dst(iss_dst), .stall(st[1]), .WrX(WrX), .waddr(waddr),
        .DataIn(DataIn), .pend_cnt(pc[1]));

    pipe_regfile_sb #(.BYPASS(1'b1), .ZERO_REG(1'b1)) u_dut2 (
        .clk(clk), .rst(rst), .raddr_1(raddr_1), .raddr_2(raddr_2),
        .out_data_1(o1[2]), .out_data_2(o2[2]), .rd1_use(rd1_use), .rd2_use(rd2_use),
        .iss_en(iss_en), .iss_dst(iss_dst), .stall(st[2]), .WrX(WrX), .waddr(waddr),
        .DataIn(DataIn), .pend_cnt(pc[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit cb(int c); return c != 1; endfunction
    function automatic bit cz(int c); return c == 2; endfunction

    // A register is "fresh this cycle" when a writeback to it is visible on the bus.
    function automatic bit wr_hit(logic [AW-1:0] a); return WrX && (waddr == a); endfunction

    function automatic logic [W-1:0] m_rd(int c, logic [AW-1:0] a);
        if (cz(c) && a == 0)     return '0;
        if (cb(c) && wr_hit(a))  return DataIn;
        return mm[c][a];
    endfunction

    function automatic bit m_busy(int c, logic [AW-1:0] a);
        if (cz(c) && a == 0) return 1'b0;
        return pp[c][a] && !(cb(c) && wr_hit(a));
    endfunction

    function automatic bit m_stall(int c);
        bit hazard;
        hazard = (rd1_use && m_busy(c, raddr_1)) || (rd2_use && m_busy(c, raddr_2)) ||
                 (pp[c][iss_dst] && !wr_hit(iss_dst));
        return iss_en && hazard;
    endfunction

    function automatic int m_cnt(int c);
        int n = 0;
        for (int r = 0; r < D; r++) n += int'(pp[c][r]);
        return n;
    endfunction

    task automatic idle();
        rst = 0; WrX = 0; waddr = '0; DataIn = '0; iss_en = 0; iss_dst = '0;
        raddr_1 = '0; raddr_2 = '0; rd1_use = 0; rd2_use = 0;
    endtask

    task automatic model_reset();
        for (int c = 0; c < 3; c++)
            for (int r = 0; r < D; r++) begin
                mm[c][r] = RF_RESET_VAL;
                pp[c][r] = 1'b0;
            end
    endtask

    // Inputs are already applied; sample at the falling edge and compare.
    task automatic eval();
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("rd1_c%0d", c),   32'(o1[c]), 32'(m_rd(c, raddr_1)));
            chk($sformatf("rd2_c%0d", c),   32'(o2[c]), 32'(m_rd(c, raddr_2)));
            chk($sformatf("stall_c%0d", c), 32'(st[c]), 32'(m_stall(c)));
            chk($sformatf("pcnt_c%0d", c),  32'(pc[c]), 32'(m_cnt(c)));
        end
    endtask

    // Commit the cycle into the reference model, then move past the edge.
    task automatic adv();
        bit s;
        for (int c = 0; c < 3; c++) begin
            if (rst) begin
                for (int r = 0; r < D; r++) begin
                    mm[c][r] = RF_RESET_VAL;
                    pp[c][r] = 1'b0;
                end
            end else begin
                s = m_stall(c);
                if (WrX && !(cz(c) && waddr == 0)) mm[c][waddr] = DataIn;
                if (WrX) pp[c][waddr] = 1'b0;
                if (iss_en && !s && !(cz(c) && iss_dst == 0)) pp[c][iss_dst] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int saved;
        idle();
        rst = 1;
        @(posedge clk); #1;
        model_reset();

        // Reset with writeback/issue-free bus, then sweep every register.
        idle(); rst = 1; eval();
        chk("rst_stall", 32'(st[0]), 32'd0);
        adv();
        for (int r = 0; r < D; r++) begin
            idle(); raddr_1 = AW'(r); raddr_2 = AW'(D-1-r); eval();
            if (r != 0) chk("rst_val", 32'(o1[2]), 32'h0000ABCD);
            adv();
        end
        chk("rst_pcnt", 32'(pc[0]), 32'd0);

        // Write then read, with and without same-cycle bypass.
        idle(); WrX = 1; waddr = 5; DataIn = 16'h1234; raddr_2 = 5; eval();
        chk("byp_on",  32'(o2[0]), 32'h1234);
        chk("byp_off", 32'(o2[1]), 32'hABCD);
        adv();
        idle(); raddr_1 = 5; eval();
        chk("wr_rd", 32'(o1[1]), 32'h1234);
        adv();

        // RAW hazard and its resolution by a bypassed writeback.
        idle(); iss_en = 1; iss_dst = 3; eval(); adv();
        chk("raw_pc", 32'(pc[0]), 32'd1);
        idle(); iss_en = 1; iss_dst = 9; raddr_1 = 3; rd1_use = 1; eval();
        chk("raw_stall", 32'(st[0]), 32'd1);
        adv();
        idle(); iss_en = 1; iss_dst = 9; raddr_1 = 3; rd1_use = 0; eval();
        chk("raw_nouse", 32'(st[0]), 32'd0);
        adv();
        idle(); iss_en = 1; iss_dst = 10; raddr_1 = 3; rd1_use = 1;
        WrX = 1; waddr = 3; DataIn = 16'h5555; eval();
        chk("raw_byp_st", 32'(st[0]), 32'd0);
        chk("raw_byp_d",  32'(o1[0]), 32'h5555);
        chk("raw_nobyp",  32'(st[1]), 32'd1);
        adv();

        // WAW stall, then writeback/issue collision on the same register.
        idle(); iss_en = 1; iss_dst = 7; eval(); adv();
        idle(); iss_en = 1; iss_dst = 7; eval();
        chk("waw_stall", 32'(st[0]), 32'd1);
        adv();
        saved = int'(pc[0]);
        idle(); iss_en = 1; iss_dst = 7; WrX = 1; waddr = 7; DataIn = 16'h0777; eval();
        chk("coll_stall", 32'(st[0]), 32'd0);
        adv();
        chk("coll_pc", 32'(pc[0]), 32'(saved));
        idle(); iss_en = 1; iss_dst = 7; eval();
        chk("coll_pend", 32'(st[0]), 32'd1);
        adv();

        // Hardwired zero register.
        idle(); WrX = 1; waddr = 0; DataIn = 16'hFFFF; raddr_1 = 0; eval();
        chk("z_byp", 32'(o1[2]), 32'd0);
        adv();
        idle(); raddr_1 = 0; eval();
        chk("z_rd",  32'(o1[2]), 32'd0);
        chk("nz_rd", 32'(o1[0]), 32'hFFFF);
        adv();
        saved = int'(pc[2]);
        idle(); iss_en = 1; iss_dst = 0; eval(); adv();
        chk("z_pc", 32'(pc[2]), 32'(saved));

        // Reset in the middle of activity, with a colliding writeback.
        idle(); rst = 1; eval(); adv();
        for (int r = 1; r <= 4; r++) begin
            idle(); iss_en = 1; iss_dst = AW'(r); eval(); adv();
        end
        chk("mid_pc4", 32'(pc[0]), 32'd4);
        idle(); rst = 1; WrX = 1; waddr = 2; DataIn = 16'h1111; eval(); adv();
        chk("mid_pc0", 32'(pc[0]), 32'd0);
        idle(); raddr_1 = 2; eval();
        chk("mid_reg2", 32'(o1[0]), 32'hABCD);
        adv();

        // Random traffic; narrow address range half the time to force collisions.
        for (int i = 0; i < 600; i++) begin
            int amax;
            amax = ($urandom_range(0, 1) != 0) ? 3 : D - 1;
            idle();
            rst     = ($urandom_range(0, 99) < 2);
            WrX     = ($urandom_range(0, 99) < 45);
            waddr   = AW'($urandom_range(0, amax));
            DataIn  = W'($urandom);
            iss_en  = !rst && ($urandom_range(0, 99) < 55);
            iss_dst = AW'($urandom_range(0, amax));
            raddr_1 = AW'($urandom_range(0, amax));
            raddr_2 = AW'($urandom_range(0, amax));
            rd1_use = $urandom_range(0, 1) != 0;
            rd2_use = $urandom_range(0, 1) != 0;
            eval();
            adv();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
